// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

  typedef enum bit [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } state_t;

  // Width of requester indices; wide enough for up to 8 requesters.
  localparam int IDX_W = 3;

  function automatic int calc_clk_count(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above pointer, wrapping.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    grant = '0;
    index = '0;
    any   = 1'b0;
    // Upper segment [pointer, N) has priority over the wrapped segment [0, pointer).
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && i >= int'(pointer)) begin
        any      = 1'b1;
        index    = IDX_W'(i);
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && i < int'(pointer)) begin
        any      = 1'b1;
        index    = IDX_W'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uarttx transmitter between NUM_REQ byte producers;
// holds new_data for a full bit-clock period and acks the winner after tx_done.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int clk_frequency = 10000000,
  parameter int baud_rate     = 9600,
  parameter int NUM_REQ       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 tx_new_data,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 timeout_err
);

  localparam int CLK_COUNT      = calc_clk_count(clk_frequency, baud_rate);
  localparam int HOLD_CYCLES    = CLK_COUNT + 4;
  localparam int TIMEOUT_CYCLES = 12 * CLK_COUNT;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [7:0]         win_data;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         done_sync;
  logic               done_prev;
  logic               done_pulse;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (win_oh),
    .index   (win_idx),
    .any     (win_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_data = req_data[8*i +: 8];
    end
  end

  // tx_done comes from the transmitter's bit-clock logic; only a fresh rising edge counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_sync <= '0;
      done_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the previous stage's old value.
      done_sync <= {done_sync[0], tx_done};
      done_prev <= done_sync[1];
    end
  end

  assign done_pulse = done_sync[1] & ~done_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      grant_id    <= '0;
      grant_oh    <= '0;
      busy        <= 1'b0;
      tx_new_data <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      gnt         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            tx_data     <= win_data;
            grant_id    <= win_idx;
            grant_oh    <= win_oh;
            busy        <= 1'b1;
            tx_new_data <= 1'b1;
            cnt         <= '0;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == HOLD_LAST) begin
            tx_new_data <= 1'b0;
            cnt         <= '0;
            state       <= WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          // A real completion beats a coincident timeout.
          if (done_pulse) begin
            gnt   <= grant_oh;
            state <= ACK;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            gnt         <= grant_oh;
            state       <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + IDX_W'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy        <= 1'b0;
          tx_new_data <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter that
// raises tx_done 100 cycles after each new_data rising edge.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLD    = 14;
  localparam int LAT_OK  = 103;  // 100 model cycles + 2 sync flops + 1 edge register
  localparam int LAT_TMO = 134;  // 14 launch cycles + 120 timeout cycles

  typedef struct {
    int id;
    int data;
    int tmo;
    int lat;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic [2:0]      grant_id;
  logic            busy;
  logic            tx_new_data;
  logic [7:0]      tx_data;
  logic            tx_done = 1'b0;
  logic            timeout_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_timeouts = 0;
  exp_t exp_q[$];
  exp_t e;

  bit   done_en = 1'b1;
  bit   stale_hold = 1'b0;
  int   mcnt = 0;
  bit   mactive = 1'b0;
  bit   m_nd_prev = 1'b0;

  int   nd_len = 0;
  bit   mon_nd_prev = 1'b0;
  int   launch_cyc = 0;

  uart_tx_arbiter #(
    .clk_frequency (96000),
    .baud_rate     (9600),
    .NUM_REQ       (NREQ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .grant_id    (grant_id),
    .busy        (busy),
    .tx_new_data (tx_new_data),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input int id, input int data, input int tmo, input int lat);
    exp_t x;
    x.id = id; x.data = data; x.tmo = tmo; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_grants(input int n, input logic [NREQ-1:0] drop);
    int seen = 0;
    int budget = n * 300;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (gnt != 0) begin
        seen++;
        req = req & ~(gnt & drop);
      end
    end
    check("grant_wait", seen, n);
  endtask

  task automatic wait_busy();
    int budget = 10;
    while (!busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("busy_wait", busy, 1);
  endtask

  // Behavioural transmitter: tx_done stays high until the next launch unless stale_hold keeps it.
  always @(negedge clk) begin
    if (tx_new_data && !m_nd_prev) begin
      mcnt    = 0;
      mactive = 1'b1;
      if (!stale_hold) tx_done = 1'b0;
    end else if (mactive) begin
      mcnt++;
      if (stale_hold && mcnt == 30) tx_done = 1'b0;
      if (mcnt == 100) begin
        mactive = 1'b0;
        if (done_en) tx_done = 1'b1;
      end
    end
    m_nd_prev = tx_new_data;
  end

  // Monitor: new_data pulse width, and every gnt against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      nd_len      = 0;
      mon_nd_prev = 1'b0;
    end else begin
      if (tx_new_data) begin
        if (!mon_nd_prev) launch_cyc = cyc;
        nd_len++;
      end else if (mon_nd_prev) begin
        check("nd_width", nd_len, HOLD);
        nd_len = 0;
      end
      mon_nd_prev = tx_new_data;
      if (timeout_err) n_timeouts++;
      if (gnt != 0) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", gnt, 0);
        end else begin
          e = exp_q.pop_front();
          check("gnt_onehot", gnt, 1 << e.id);
          check("grant_id", grant_id, e.id);
          check("tx_data", tx_data, e.data);
          check("timeout_err", timeout_err, e.tmo);
          check("gnt_latency", cyc - launch_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_new_data", tx_new_data, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Round robin with all requests held: 0,1,2,3,0.
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) push(i % 4, 8'h10 + (i % 4), 0, LAT_OK);
    req = 4'b1111;
    wait_grants(5, 4'b0000);
    req = '0;
    repeat (3) @(negedge clk);

    // Single request from requester 1; arbitration latency.
    req_data = 32'h0000_A500;
    push(1, 8'hA5, 0, LAT_OK);
    req = 4'b0010;
    @(negedge clk);
    check("busy_next_cycle", busy, 1);
    check("nd_next_cycle", tx_new_data, 1);
    check("tx_data_launch", tx_data, 8'hA5);
    wait_grants(1, 4'b0010);
    repeat (3) @(negedge clk);

    // Fairness: req0 held throughout, req2 joins mid-transfer and is served next.
    req_data = {8'h00, 8'h22, 8'h00, 8'h20};
    push(0, 8'h20, 0, LAT_OK);
    push(2, 8'h22, 0, LAT_OK);
    push(0, 8'h20, 0, LAT_OK);
    req = 4'b0001;
    wait_busy();
    req_data[7:0] = 8'hEE;  // ignored once latched
    req[2] = 1'b1;
    @(negedge clk);
    req_data[7:0] = 8'h20;
    wait_grants(3, 4'b0100);
    req = '0;
    repeat (3) @(negedge clk);

    // Timeout: transmitter never completes; next request still proceeds.
    done_en = 1'b0;
    req_data = 32'h3C00_0000;
    push(3, 8'h3C, 1, LAT_TMO);
    req = 4'b1000;
    wait_grants(1, 4'b1000);
    done_en = 1'b1;
    repeat (3) @(negedge clk);
    req_data = 32'h0000_005A;
    push(0, 8'h5A, 0, LAT_OK);
    req = 4'b0001;
    wait_grants(1, 4'b0001);
    repeat (3) @(negedge clk);

    // Stale done: tx_done still high from the previous byte on WAIT_DONE entry.
    stale_hold = 1'b1;
    req_data = 32'h0000_C300;
    push(1, 8'hC3, 0, LAT_OK);
    req = 4'b0010;
    wait_grants(1, 4'b0010);
    stale_hold = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during WAIT_DONE; pointer (currently 2) must return to 0.
    req_data = 32'h9900_0000;
    req = 4'b1000;
    wait_busy();
    for (int i = 0; i < 30 && tx_new_data; i++) @(negedge clk);
    check("nd_fall_wait", tx_new_data, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_new_data", tx_new_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_tx_data", tx_data, 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    req_data = {8'h00, 8'h82, 8'h00, 8'h81};
    push(0, 8'h81, 0, LAT_OK);
    push(2, 8'h82, 0, LAT_OK);
    req = 4'b0101;
    wait_grants(2, 4'b0101);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("timeout_pulses", n_timeouts, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
